// File: rtl/board_state_fsm.sv
// board_state_fsm: minesweeper board-state engine for a ROWS x COLS grid.
// Tracks the cursor, per-cell revealed and flag bits, the revealed count, and
// runs a multi-pass flood-reveal sweep when a zero-neighbour cell is selected.
//
// Optional feature macro: BOARD_FLAGS_EN
//   defined   - btn_flag toggles per-cell flags; flags block sel and flood reveal
//   undefined - btn_flag ignored, flagged_flat tied 0, no flag storage
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load_new_map      clears board state (cursor kept), aborts any sweep
//   btn_*             single-cycle debounced button pulses
//   mine_flat         bit y*COLS+x set = cell is a mine
//   zero_flat         bit set = cell has no adjacent mines
//   mine_count        number of mines on the current map
//   revealed_flat     revealed bits, same indexing
//   flagged_flat      flag bits, same indexing
//   cursor_x/y        cursor column/row
//   num_revealed      count of revealed cells
//   busy              flood sweep in progress
//   lost              sticky, a mine was revealed
//   won               all safe cells revealed and not lost
//
// state | meaning
// IDLE  | accepting buttons, one per cycle
// SWEEP | flood-reveal scan, one cell per cycle, buttons dropped
// OVER  | game finished, outputs hold until load_new_map or reset
module board_state_fsm #(
  parameter  int COLS = 8,
  parameter  int ROWS = 8,
  localparam int N    = COLS * ROWS,
  localparam int CW   = $clog2(N + 1),
  localparam int XW   = $clog2(COLS),
  localparam int YW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_new_map,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_sel,
  input  logic          btn_flag,
  input  logic [N-1:0]  mine_flat,
  input  logic [N-1:0]  zero_flat,
  input  logic [CW-1:0] mine_count,
  output logic [N-1:0]  revealed_flat,
  output logic [N-1:0]  flagged_flat,
  output logic [XW-1:0] cursor_x,
  output logic [YW-1:0] cursor_y,
  output logic [CW-1:0] num_revealed,
  output logic          busy,
  output logic          lost,
  output logic          won
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, SWEEP, OVER} state_t;

  state_t        state;
  logic [IW-1:0] si;
  logic [XW-1:0] sx;
  logic [YW-1:0] sy;
  logic          pass_changed;

  logic [IW-1:0] cur_idx;
  logic [N-1:0]  zr;
  logic          nbr_hit;
  logic          flag_cur;
  logic          flag_sweep;
  logic          sweep_hit;

`ifdef BOARD_FLAGS_EN
  logic [N-1:0] flagged;
  assign flagged_flat = flagged;
  assign flag_cur     = flagged[cur_idx];
  assign flag_sweep   = flagged[si];
`else
  logic unused_btn_flag;
  assign unused_btn_flag = btn_flag;
  assign flagged_flat    = '0;
  assign flag_cur        = 1'b0;
  assign flag_sweep      = 1'b0;
`endif

  assign cur_idx = IW'(cursor_y) * IW'(COLS) + IW'(cursor_x);
  assign zr      = revealed_flat & zero_flat;
  assign won     = (num_revealed == (CW'(N) - mine_count)) && !lost;

  // Neighbour test for the sweep cell: the loop index is a constant per
  // unrolled iteration, so each candidate cell's coordinates are fixed and
  // only the comparison against (sx, sy) is real logic. Edge cells simply
  // have no out-of-grid candidates, so there is no wrap.
  always_comb begin
    nbr_hit = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (zr[c] && (c != int'(si)) &&
          ((c % COLS) - int'(sx) <= 1) && (int'(sx) - (c % COLS) <= 1) &&
          ((c / COLS) - int'(sy) <= 1) && (int'(sy) - (c / COLS) <= 1))
        nbr_hit = 1'b1;
    end
  end

  assign sweep_hit = !revealed_flat[si] && !flag_sweep && !mine_flat[si] && nbr_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      revealed_flat <= '0;
      cursor_x      <= '0;
      cursor_y      <= '0;
      num_revealed  <= '0;
      busy          <= 1'b0;
      lost          <= 1'b0;
      si            <= '0;
      sx            <= '0;
      sy            <= '0;
      pass_changed  <= 1'b0;
`ifdef BOARD_FLAGS_EN
      flagged       <= '0;
`endif
    end else if (load_new_map) begin
      state         <= IDLE;
      revealed_flat <= '0;
      num_revealed  <= '0;
      busy          <= 1'b0;
      lost          <= 1'b0;
      pass_changed  <= 1'b0;
`ifdef BOARD_FLAGS_EN
      flagged       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (won) begin
            state <= OVER;
          end else if (btn_up) begin
            cursor_y <= (cursor_y == '0) ? YW'(ROWS - 1) : cursor_y - YW'(1);
          end else if (btn_down) begin
            cursor_y <= (cursor_y == YW'(ROWS - 1)) ? '0 : cursor_y + YW'(1);
          end else if (btn_left) begin
            cursor_x <= (cursor_x == '0) ? XW'(COLS - 1) : cursor_x - XW'(1);
          end else if (btn_right) begin
            cursor_x <= (cursor_x == XW'(COLS - 1)) ? '0 : cursor_x + XW'(1);
          end else if (btn_sel) begin
            if (!revealed_flat[cur_idx] && !flag_cur) begin
              revealed_flat[cur_idx] <= 1'b1;
              num_revealed           <= num_revealed + CW'(1);
              if (mine_flat[cur_idx]) begin
                lost  <= 1'b1;
                state <= OVER;
              end else if (zero_flat[cur_idx]) begin
                state        <= SWEEP;
                busy         <= 1'b1;
                si           <= '0;
                sx           <= '0;
                sy           <= '0;
                pass_changed <= 1'b0;
              end
            end
`ifdef BOARD_FLAGS_EN
          end else if (btn_flag) begin
            if (!revealed_flat[cur_idx])
              flagged[cur_idx] <= !flagged[cur_idx];
`endif
          end
        end
        SWEEP: begin
          if (sweep_hit) begin
            revealed_flat[si] <= 1'b1;
            num_revealed      <= num_revealed + CW'(1);
          end
          if (si == IW'(N - 1)) begin
            // A reveal on the last cell also counts as a change for this pass.
            if (pass_changed || sweep_hit) begin
              si           <= '0;
              sx           <= '0;
              sy           <= '0;
              pass_changed <= 1'b0;
            end else begin
              busy  <= 1'b0;
              state <= won ? OVER : IDLE;
            end
          end else begin
            si           <= si + IW'(1);
            pass_changed <= pass_changed | sweep_hit;
            if (sx == XW'(COLS - 1)) begin
              sx <= '0;
              sy <= sy + YW'(1);
            end else begin
              sx <= sx + XW'(1);
            end
          end
        end
        OVER: begin
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_fsm.sv
module tb_board_state_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_new_map = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic        btn_right = 1'b0, btn_sel = 1'b0, btn_flag = 1'b0;
  logic [63:0] mine_flat = '0;
  logic [63:0] zero_flat = '0;
  logic [6:0]  mine_count = 7'd10;
  logic [63:0] revealed_flat, flagged_flat;
  logic [2:0]  cursor_x, cursor_y;
  logic [6:0]  num_revealed;
  logic        busy, lost, won;

  logic        b5_left = 1'b0, b5_right = 1'b0, b5_zero = 1'b0;
  logic [24:0] m5_mine = '0, m5_zero = '0;
  logic [4:0]  m5_count = 5'd3;
  logic [24:0] r5_rev, r5_flag;
  logic [2:0]  c5_x, c5_y;
  logic [4:0]  n5_rev;
  logic        busy5, lost5, won5;

  int total = 0;
  int bad   = 0;
  bit done;

  always #5 clk = ~clk;

  board_state_fsm #(.COLS(8), .ROWS(8)) dut (
    .clk(clk), .rst_n(rst_n), .load_new_map(load_new_map),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .btn_flag(btn_flag),
    .mine_flat(mine_flat), .zero_flat(zero_flat), .mine_count(mine_count),
    .revealed_flat(revealed_flat), .flagged_flat(flagged_flat),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .num_revealed(num_revealed),
    .busy(busy), .lost(lost), .won(won)
  );

  board_state_fsm #(.COLS(5), .ROWS(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .load_new_map(b5_zero),
    .btn_up(b5_zero), .btn_down(b5_zero), .btn_left(b5_left),
    .btn_right(b5_right), .btn_sel(b5_zero), .btn_flag(b5_zero),
    .mine_flat(m5_mine), .zero_flat(m5_zero), .mine_count(m5_count),
    .revealed_flat(r5_rev), .flagged_flat(r5_flag),
    .cursor_x(c5_x), .cursor_y(c5_y), .num_revealed(n5_rev),
    .busy(busy5), .lost(lost5), .won(won5)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // 0 up, 1 down, 2 left, 3 right, 4 sel, 5 flag, 6 left5, 7 right5
  task automatic press(input int code);
    case (code)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      2: btn_left = 1'b1;
      3: btn_right = 1'b1;
      4: btn_sel = 1'b1;
      5: btn_flag = 1'b1;
      6: b5_left = 1'b1;
      default: b5_right = 1'b1;
    endcase
    @(posedge clk); #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_sel = 0; btn_flag = 0; b5_left = 0; b5_right = 0;
  endtask

  task automatic press_n(input int code, input int n);
    for (int i = 0; i < n; i++) press(code);
  endtask

  task automatic load_map();
    load_new_map = 1'b1;
    @(posedge clk); #1;
    load_new_map = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("sweep_finished", 64'(done), 64'd1);
  endtask

  logic [63:0] exp_flood;
  logic [6:0]  exp_count;
  logic        exp_won;
  logic [63:0] exp_flag;

  initial begin
    // Reset
    #12;
    chk("rst_revealed", revealed_flat, 64'd0);
    chk("rst_flagged", flagged_flat, 64'd0);
    chk("rst_cursor_x", 64'(cursor_x), 64'd0);
    chk("rst_cursor_y", 64'(cursor_y), 64'd0);
    chk("rst_count", 64'(num_revealed), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_lost", 64'(lost), 64'd0);
    chk("rst_won", 64'(won), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Cursor wrap on 8x8 and 5x5
    press_n(2, 3);
    press(0);
    chk("wrap_x8", 64'(cursor_x), 64'd5);
    chk("wrap_y8", 64'(cursor_y), 64'd7);
    press(6);
    chk("wrap_left5", 64'(c5_x), 64'd4);
    press(7);
    chk("wrap_right5", 64'(c5_x), 64'd0);

    // No-zero map, sel at (2,3) twice
    mine_flat = '0; zero_flat = '0; mine_count = 7'd10;
    load_map();
    press_n(2, 3);
    press_n(0, 4);
    chk("move_x", 64'(cursor_x), 64'd2);
    chk("move_y", 64'(cursor_y), 64'd3);
    press(4);
    chk("sel1_busy", 64'(busy), 64'd0);
    chk("sel1_rev", revealed_flat, 64'h0000_0000_0400_0000);
    chk("sel1_count", 64'(num_revealed), 64'd1);
    press(4);
    chk("sel2_rev", revealed_flat, 64'h0000_0000_0400_0000);
    chk("sel2_count", 64'(num_revealed), 64'd1);
    chk("sel2_busy", 64'(busy), 64'd0);

    // Mine at (0,0)
    mine_flat = 64'h1; zero_flat = '0; mine_count = 7'd1;
    load_map();
    chk("load_clears", revealed_flat, 64'd0);
    press_n(2, 2);
    press_n(0, 3);
    press(4);
    chk("mine_lost", 64'(lost), 64'd1);
    chk("mine_rev", revealed_flat, 64'h1);
    chk("mine_count", 64'(num_revealed), 64'd1);
    chk("mine_won", 64'(won), 64'd0);
    press(3);
    press(1);
    press(4);
    chk("over_x", 64'(cursor_x), 64'd0);
    chk("over_y", 64'(cursor_y), 64'd0);
    chk("over_count", 64'(num_revealed), 64'd1);
    chk("over_rev", revealed_flat, 64'h1);
    load_map();
    chk("reload_lost", 64'(lost), 64'd0);
    chk("reload_count", 64'(num_revealed), 64'd0);
    chk("reload_rev", revealed_flat, 64'd0);

    // Flood from (0,0), single mine at (7,7), flag at (3,3) first
    mine_flat = 64'h8000_0000_0000_0000;
    zero_flat = 64'h3F3F_FFFF_FFFF_FFFF;
    mine_count = 7'd1;
    load_map();
    press_n(3, 3);
    press_n(1, 3);
    press(5);
`ifdef BOARD_FLAGS_EN
    exp_flag  = 64'h0000_0000_0800_0000;
    exp_flood = 64'h7FFF_FFFF_F7FF_FFFF;
    exp_count = 7'd62;
    exp_won   = 1'b0;
`else
    exp_flag  = 64'd0;
    exp_flood = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_count = 7'd63;
    exp_won   = 1'b1;
`endif
    chk("flag_bit", flagged_flat, exp_flag);
    press_n(2, 3);
    press_n(0, 3);
    press(4);
    chk("flood_busy", 64'(busy), 64'd1);
    chk("flood_first", 64'(num_revealed), 64'd1);
    press(0);
    chk("flood_btn_ign", 64'(cursor_y), 64'd0);
    wait_idle(5000);
    chk("flood_count", 64'(num_revealed), 64'(exp_count));
    chk("flood_rev", revealed_flat, exp_flood);
    chk("flood_won", 64'(won), 64'(exp_won));
    chk("flood_cursor", 64'({cursor_y, cursor_x}), 64'd0);

    // load_new_map mid-sweep
    load_map();
    press(4);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", 64'(busy), 64'd1);
    press(1);
    chk("mid_btn_ign", 64'(cursor_y), 64'd0);
    load_map();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rev", revealed_flat, 64'd0);
    chk("abort_count", 64'(num_revealed), 64'd0);

    // Asynchronous reset mid-sweep
    press(3);
    press(4);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_rev", revealed_flat, 64'd0);
    chk("arst_count", 64'(num_revealed), 64'd0);
    chk("arst_x", 64'(cursor_x), 64'd0);
    chk("arst_lost", 64'(lost), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
